// File: rtl/print_pkg.sv
// rtl/print_pkg.sv - shared state encoding, syscall codes and power-of-ten table for print_engine
package print_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EMIT,
        ST_INT,
        ST_HALT
    } state_t;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR = 32'd4;
    localparam logic [31:0] SYS_EXIT      = 32'd10;

    // Index 0 is the most significant decimal place of a 32-bit value.
    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1000000000;
            4'd1:    pow10 = 32'd100000000;
            4'd2:    pow10 = 32'd10000000;
            4'd3:    pow10 = 32'd1000000;
            4'd4:    pow10 = 32'd100000;
            4'd5:    pow10 = 32'd10000;
            4'd6:    pow10 = 32'd1000;
            4'd7:    pow10 = 32'd100;
            4'd8:    pow10 = 32'd10;
            default: pow10 = 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/print_int_digits.sv
// rtl/print_int_digits.sv - signed decimal digit generator by repeated subtraction (used with PRINT_INT_EN)
module print_int_digits
    import print_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        next,
    output logic        char_valid,
    output logic [7:0]  char_data,
    output logic        last
);

    logic [31:0] mag;
    logic [3:0]  idx;
    logic [3:0]  digit;
    logic        started;
    logic        sign_pend;
    logic        active;
    logic        ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag       <= '0;
            idx       <= '0;
            digit     <= '0;
            started   <= 1'b0;
            sign_pend <= 1'b0;
            active    <= 1'b0;
            ready     <= 1'b0;
        end else if (start) begin
            // Two's-complement negate leaves 0x80000000 as its own unsigned magnitude.
            mag       <= value[31] ? (~value + 32'd1) : value;
            sign_pend <= value[31];
            idx       <= '0;
            digit     <= '0;
            started   <= 1'b0;
            active    <= 1'b1;
            ready     <= 1'b0;
        end else if (active) begin
            if (sign_pend) begin
                if (next) sign_pend <= 1'b0;
            end else if (ready) begin
                if (next) begin
                    ready   <= 1'b0;
                    digit   <= '0;
                    started <= 1'b1;
                    if (idx == 4'd9) active <= 1'b0;
                    else             idx    <= idx + 4'd1;
                end
            end else if (mag >= pow10(idx)) begin
                mag   <= mag - pow10(idx);
                digit <= digit + 4'd1;
            end else if (digit == 4'd0 && !started && idx != 4'd9) begin
                idx <= idx + 4'd1;
            end else begin
                ready <= 1'b1;
            end
        end
    end

    assign char_valid = active && (sign_pend || ready);
    assign char_data  = sign_pend ? 8'h2D : (ready ? (8'h30 + {4'h0, digit}) : 8'h00);
    assign last       = active && ready && !sign_pend && idx == 4'd9;

endmodule

// File: rtl/print_engine.sv
// rtl/print_engine.sv - syscall print/exit engine; optional integer printing under PRINT_INT_EN
module print_engine
    import print_pkg::*;
#(
    parameter int MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sys_valid,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        busy,
    output logic        exit
);

    state_t      state;
    logic [31:0] ptr;
    logic [31:0] count;
    logic [31:0] word;
    logic [7:0]  cur_byte;
    logic        accept;

    always_comb begin
        case (ptr[1:0])
            2'd0:    cur_byte = word[31:24];
            2'd1:    cur_byte = word[23:16];
            2'd2:    cur_byte = word[15:8];
            default: cur_byte = word[7:0];
        endcase
    end

`ifdef PRINT_INT_EN
    logic       int_valid;
    logic [7:0] int_char;
    logic       int_last;

    print_int_digits u_digits (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (state == ST_IDLE && sys_valid && v0 == SYS_PRINT_INT),
        .value      (a0),
        .next       (state == ST_INT && char_ready),
        .char_valid (int_valid),
        .char_data  (int_char),
        .last       (int_last)
    );

    assign accept = sys_valid && (v0 == SYS_PRINT_STR || v0 == SYS_EXIT || v0 == SYS_PRINT_INT);
`else
    assign accept = sys_valid && (v0 == SYS_PRINT_STR || v0 == SYS_EXIT);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            count <= '0;
            word  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sys_valid && v0 == SYS_PRINT_STR) begin
                        ptr   <= a0;
                        count <= '0;
                        state <= ST_FETCH;
                    end else if (sys_valid && v0 == SYS_EXIT) begin
                        state <= ST_HALT;
`ifdef PRINT_INT_EN
                    end else if (sys_valid && v0 == SYS_PRINT_INT) begin
                        state <= ST_INT;
`endif
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        word  <= mem_rdata;
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (cur_byte == 8'h00) begin
                        state <= ST_IDLE;
                    end else if (char_ready) begin
                        ptr   <= ptr + 32'd1;
                        count <= count + 32'd1;
                        // Length limit wins over any bytes left in the word.
                        if (count + 32'd1 >= 32'(MAX_LEN)) state <= ST_IDLE;
                        else if (ptr[1:0] == 2'b11)        state <= ST_FETCH;
                    end
                end
`ifdef PRINT_INT_EN
                ST_INT: begin
                    if (int_valid && char_ready && int_last) state <= ST_IDLE;
                end
`endif
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        char_valid = 1'b0;
        char_data  = 8'h00;
        case (state)
            ST_EMIT: begin
                if (cur_byte != 8'h00) begin
                    char_valid = 1'b1;
                    char_data  = cur_byte;
                end
            end
`ifdef PRINT_INT_EN
            ST_INT: begin
                char_valid = int_valid;
                char_data  = int_char;
            end
`endif
            default: ;
        endcase
    end

    assign mem_req  = (state == ST_FETCH);
    assign mem_addr = mem_req ? {ptr[31:2], 2'b00} : 32'h0;
    assign busy     = (state != ST_IDLE) || accept;
    assign exit     = (state == ST_HALT);

endmodule

// File: tb/tb_print_engine.sv
// tb/tb_print_engine.sv - table-driven bench for print_engine (MAX_LEN=4; PRINT_INT_EN cases when defined)
module tb_print_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sys_valid;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        busy;
    logic        exit;

    print_engine #(.MAX_LEN(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sys_valid  (sys_valid),
        .v0         (v0),
        .a0         (a0),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy),
        .exit       (exit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v0;
        logic [31:0] a0;
        logic        busy0;
        int          len;
        logic [95:0] str;
        int          nfetch;
        logic [31:0] f0;
        logic [31:0] f1;
    } vec_t;

    vec_t        vt[12];
    int          nvec;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  chars[$];
    logic [31:0] fetches[$];
    logic        overlap = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: mem_word = 32'h5900_0000;
            32'h0000_0100: mem_word = 32'h4869_2100;
            32'h0000_0200: mem_word = 32'h0000_0041;
            32'h0000_0204: mem_word = 32'h4243_0000;
            32'h0000_0300: mem_word = 32'h3132_3334;
            32'h0000_0304: mem_word = 32'h3536_3738;
            32'h0000_0308: mem_word = 32'h3930_0000;
            32'h0000_0400: mem_word = 32'h5841_4200;
            32'h0000_0500: mem_word = 32'h0000_0000;
            32'hFFFF_FFFC: mem_word = 32'h0000_005A;
            default:       mem_word = 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Memory answers one cycle after a request and logs each fetched address.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                fetches.push_back(mem_addr);
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (char_valid && char_ready) chars.push_back(char_data);
            if (mem_req && char_valid) overlap = 1'b1;
        end
    end

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            #2;
            if (!busy) break;
        end
        if (k == 200) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [31:0] code, input logic [31:0] arg);
        @(negedge clk);
        sys_valid = 1'b1;
        v0        = code;
        a0        = arg;
    endtask

    task automatic wait_char(input string nm);
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            #2;
            if (char_valid) break;
        end
        if (k == 50) chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        sys_valid  = 1'b0;
        v0         = 32'h0;
        a0         = 32'h0;
        char_ready = 1'b1;

        vt[0] = '{32'd4, 32'h0000_0100, 1'b1, 3, {24'h486921, 72'h0}, 1, 32'h0000_0100, 32'h0};
        vt[1] = '{32'd4, 32'h0000_0203, 1'b1, 3, {24'h414243, 72'h0}, 2, 32'h0000_0200, 32'h0000_0204};
        vt[2] = '{32'd4, 32'h0000_0300, 1'b1, 4, {32'h31323334, 64'h0}, 1, 32'h0000_0300, 32'h0};
        vt[3] = '{32'd4, 32'h0000_0401, 1'b1, 2, {16'h4142, 80'h0}, 1, 32'h0000_0400, 32'h0};
        vt[4] = '{32'd4, 32'h0000_0500, 1'b1, 0, 96'h0, 1, 32'h0000_0500, 32'h0};
        vt[5] = '{32'd4, 32'hFFFF_FFFF, 1'b1, 2, {16'h5A59, 80'h0}, 2, 32'hFFFF_FFFC, 32'h0};
        vt[6] = '{32'd5, 32'h0000_0100, 1'b0, 0, 96'h0, 0, 32'h0, 32'h0};
`ifdef PRINT_INT_EN
        vt[7] = '{32'd1, 32'hFFFF_FECF, 1'b1, 4, {32'h2D333035, 64'h0}, 0, 32'h0, 32'h0};
        vt[8] = '{32'd1, 32'h0000_0000, 1'b1, 1, {8'h30, 88'h0}, 0, 32'h0, 32'h0};
        vt[9] = '{32'd1, 32'h8000_0000, 1'b1, 11, {88'h2D_32_31_34_37_34_38_33_36_34_38, 8'h0}, 0, 32'h0, 32'h0};
        nvec  = 10;
`else
        vt[7] = '{32'd1, 32'h0000_0100, 1'b0, 0, 96'h0, 0, 32'h0, 32'h0};
        nvec  = 8;
`endif

        repeat (3) @(negedge clk);
        #2;
        chk("rst_busy",       {31'h0, busy},       32'd0);
        chk("rst_exit",       {31'h0, exit},       32'd0);
        chk("rst_char_valid", {31'h0, char_valid}, 32'd0);
        chk("rst_mem_req",    {31'h0, mem_req},    32'd0);
        chk("rst_char_data",  {24'h0, char_data},  32'd0);
        chk("rst_mem_addr",   mem_addr,            32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            chars.delete();
            fetches.delete();
            issue(vt[i].v0, vt[i].a0);
            #2;
            chk($sformatf("v%0d_busy0", i), {31'h0, busy}, {31'h0, vt[i].busy0});
            @(negedge clk);
            sys_valid = 1'b0;
            #2;
            if (busy) wait_idle($sformatf("v%0d", i));
            chk($sformatf("v%0d_len", i), chars.size(), vt[i].len);
            for (int c = 0; c < vt[i].len && c < chars.size(); c++)
                chk($sformatf("v%0d_char%0d", i, c), {24'h0, chars[c]},
                    {24'h0, vt[i].str[95 - 8 * c -: 8]});
            chk($sformatf("v%0d_nfetch", i), fetches.size(), vt[i].nfetch);
            if (vt[i].nfetch >= 1 && fetches.size() >= 1)
                chk($sformatf("v%0d_fetch0", i), fetches[0], vt[i].f0);
            if (vt[i].nfetch >= 2 && fetches.size() >= 2)
                chk($sformatf("v%0d_fetch1", i), fetches[1], vt[i].f1);
            chk($sformatf("v%0d_idle_data", i), {24'h0, char_data}, 32'd0);
            chk($sformatf("v%0d_idle_addr", i), mem_addr, 32'd0);
        end

        // Back-pressure mid-string: output held, no re-fetch, stall kept asserted.
        chars.delete();
        fetches.delete();
        char_ready = 1'b0;
        issue(32'd4, 32'h0000_0100);
        @(negedge clk);
        sys_valid = 1'b0;
        wait_char("stall");
        chk("stall_first", {24'h0, char_data}, 32'h48);
        repeat (5) begin
            @(negedge clk);
            #2;
            chk("stall_valid", {31'h0, char_valid}, 32'd1);
            chk("stall_data",  {24'h0, char_data},  32'h48);
            chk("stall_busy",  {31'h0, busy},       32'd1);
            chk("stall_memreq", {31'h0, mem_req},   32'd0);
        end
        @(negedge clk);
        char_ready = 1'b1;
        wait_idle("stall_end");
        chk("stall_len", chars.size(), 3);
        if (chars.size() == 3) begin
            chk("stall_c0", {24'h0, chars[0]}, 32'h48);
            chk("stall_c1", {24'h0, chars[1]}, 32'h69);
            chk("stall_c2", {24'h0, chars[2]}, 32'h21);
        end
        chk("stall_nfetch", fetches.size(), 1);

        // Reset while a character is pending.
        char_ready = 1'b0;
        issue(32'd4, 32'h0000_0100);
        @(negedge clk);
        sys_valid = 1'b0;
        wait_char("rst_emit");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        chk("rste_char_valid", {31'h0, char_valid}, 32'd0);
        chk("rste_busy",       {31'h0, busy},       32'd0);
        chk("rste_exit",       {31'h0, exit},       32'd0);
        chk("rste_char_data",  {24'h0, char_data},  32'd0);
        chk("rste_mem_addr",   mem_addr,            32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        char_ready = 1'b1;

        // Exit is sticky and later syscalls are ignored.
        fetches.delete();
        issue(32'd10, 32'h0);
        #2;
        chk("halt_exit0", {31'h0, exit}, 32'd0);
        chk("halt_busy0", {31'h0, busy}, 32'd1);
        @(negedge clk);
        v0 = 32'd4;
        a0 = 32'h0000_0100;
        #2;
        chk("halt_exit1", {31'h0, exit}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            #2;
            chk("halt_exit",   {31'h0, exit},    32'd1);
            chk("halt_busy",   {31'h0, busy},    32'd1);
            chk("halt_memreq", {31'h0, mem_req}, 32'd0);
        end
        sys_valid = 1'b0;
        chk("halt_nfetch", fetches.size(), 0);
        chk("no_overlap", {31'h0, overlap}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
